mac_seq: RTL

- Parametrised, pipelined signed multiply-accumulate engine.
- Preloads a bias, then accepts a programmed number of operand pairs over a valid/ready handshake and accumulates their products.
- Presents the final sum on a valid/ready output port.
- Generalised successor of the fixed 8x8 / 21-bit MAC used in the neuron datapath; adds configurable widths, a length counter, flow control and an optional saturation mode.

---
 rtl/mac_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mac_seq.sv
// mac_seq: pipelined signed multiply-accumulate with bias preload, run-length counter and valid/ready ports.
// Optional build macro MAC_SEQ_SAT_EN: saturating accumulation plus a sticky sat_flag output.
module mac_seq #(
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 21,
  parameter int BIAS_W     = 8,
  parameter int BIAS_SHIFT = 0,
  parameter int LEN_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [BIAS_W-1:0] bias,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef MAC_SEQ_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [ACC_W-1:0]     acc, acc_nxt;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] a_x, b_x;
  logic                 prod_vld;
  logic [LEN_W-1:0]     remaining;
  logic                 start_acc;
  logic                 accept;

  // A start in DONE only counts when the pending result is consumed in the same cycle.
  assign start_acc = start && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign a_x       = PW'($signed(a));
  assign b_x       = PW'($signed(b));
  assign out       = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = (len != '0) ? ACCUM : DONE;
      ACCUM:   if (accept && (remaining == LEN_W'(1))) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE: begin
        if (start_acc)      state_nxt = (len != '0) ? ACCUM : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM) && (remaining != '0);
    busy      = (state == ACCUM) || (state == DRAIN);
    out_valid = (state == DONE);
  end

`ifdef MAC_SEQ_SAT_EN
  // Wide enough that neither the shifted bias nor acc+product can wrap before the clamp test.
  localparam int XW = ACC_W + BIAS_W + BIAS_SHIFT + 1;

  logic signed [XW-1:0] bias_x, sum_x, nxt_x;
  logic                 ovf;

  assign bias_x = XW'($signed(bias)) <<< BIAS_SHIFT;
  assign sum_x  = XW'($signed(acc)) + XW'(prod);
  assign nxt_x  = start_acc ? bias_x : sum_x;
  assign ovf    = (start_acc || prod_vld) &&
                  (nxt_x[XW-1:ACC_W-1] != {(XW-ACC_W+1){nxt_x[XW-1]}});

  always_comb begin
    acc_nxt = nxt_x[ACC_W-1:0];
    if (ovf) acc_nxt = nxt_x[XW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sat_flag <= 1'b0;
    else if (start_acc) sat_flag <= ovf;
    else if (ovf)       sat_flag <= 1'b1;
  end
`else
  logic [ACC_W-1:0] bias_w;

  assign bias_w  = ACC_W'($signed(bias)) <<< BIAS_SHIFT;
  assign acc_nxt = start_acc ? bias_w : (acc + ACC_W'(prod));
`endif

  // Product stage feeds the accumulator one cycle later, sustaining one pair per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      remaining <= '0;
    end else begin
      if (start_acc || prod_vld) acc <= acc_nxt;
      prod_vld <= accept;
      if (accept) prod <= a_x * b_x;
      if (start_acc)   remaining <= len;
      else if (accept) remaining <= remaining - LEN_W'(1);
    end
  end

endmodule
